// File: rtl/alu_result_stage.sv
// Result-capture stage after the 32-bit ALU: 2-entry in-order skid buffer toward writeback
// plus the architectural N/Z flag register. Optional branch-condition evaluation under ALU_BRANCH_COND_EN.
module alu_result_stage #(
  parameter int DEST_W = 4
) (
  input  logic              iClk,
  input  logic              iReset_n,
  input  logic              iValid,
  output logic              oReady,
  input  logic [31:0]       iRegC,
  input  logic              iNEG,
  input  logic              iZERO,
  input  logic [3:0]        iOP,
  input  logic [DEST_W-1:0] iDest,
  output logic              oValid,
  input  logic              iReady,
  output logic [31:0]       oData,
  output logic [DEST_W-1:0] oDest,
  output logic              oWrEn,
  output logic              oFlagN,
  output logic              oFlagZ,
`ifdef ALU_BRANCH_COND_EN
  input  logic [2:0]        iCond,
  output logic              oTaken,
`endif
  output logic [1:0]        oCount
);

  // Handshake: upstream transfer on iValid & oReady, downstream pop on oValid & iReady.
  // oReady comes only from registered state, so iReady never reaches it combinationally.
  logic [1:0]        count_q;
  logic              rd_ptr_q;
  logic              wr_ptr_q;
  logic              rdy_en_q;
  logic              flag_n_q;
  logic              flag_z_q;
  logic [31:0]       data_q [2];
  logic [DEST_W-1:0] dest_q [2];
  logic              wren_q [2];
`ifdef ALU_BRANCH_COND_EN
  logic              taken_q [2];

  function automatic logic cond_eval(input logic [2:0] c, input logic n, input logic z);
    logic r;
    r = 1'b0;
    case (c)
      3'd0: r = 1'b0;
      3'd1: r = 1'b1;
      3'd2: r = z;
      3'd3: r = ~z;
      3'd4: r = n;
      3'd5: r = ~n;
      3'd6: r = n | z;
      3'd7: r = ~n & ~z;
      default: r = 1'b0;
    endcase
    return r;
  endfunction
`endif

  logic push;
  logic pop;
  logic flag_upd;

  assign oReady   = (count_q != 2'd2) & rdy_en_q;
  assign oValid   = (count_q != 2'd0);
  assign push     = iValid & oReady;
  assign pop      = oValid & iReady;
  assign flag_upd = push & ((iOP == 4'd1) | (iOP == 4'd2));
  assign oCount   = count_q;
  assign oFlagN   = flag_n_q;
  assign oFlagZ   = flag_z_q;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      rdy_en_q <= 1'b0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        data_q[i]  <= '0;
        dest_q[i]  <= '0;
        wren_q[i]  <= 1'b0;
`ifdef ALU_BRANCH_COND_EN
        taken_q[i] <= 1'b0;
`endif
      end
    end else begin
      rdy_en_q <= 1'b1;
      if (push) begin
        data_q[wr_ptr_q]  <= iRegC;
        dest_q[wr_ptr_q]  <= iDest;
        wren_q[wr_ptr_q]  <= (iOP != 4'd0);
`ifdef ALU_BRANCH_COND_EN
        // Decision uses the flags as they stand before this entry's own update.
        taken_q[wr_ptr_q] <= cond_eval(iCond, flag_n_q, flag_z_q);
`endif
        wr_ptr_q <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
      if (flag_upd) begin
        flag_n_q <= iNEG;
        flag_z_q <= iZERO;
      end
    end
  end

  always_comb begin
    oData  = '0;
    oDest  = '0;
    oWrEn  = 1'b0;
`ifdef ALU_BRANCH_COND_EN
    oTaken = 1'b0;
`endif
    if (oValid) begin
      oData  = data_q[rd_ptr_q];
      oDest  = dest_q[rd_ptr_q];
      oWrEn  = wren_q[rd_ptr_q];
`ifdef ALU_BRANCH_COND_EN
      oTaken = taken_q[rd_ptr_q];
`endif
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: queue-based reference model, per-cycle compare, directed vectors.
// Build with +define+ALU_BRANCH_COND_EN to cover the branch-condition option.
module tb_alu_result_stage;
  localparam int DEST_W = 4;
  localparam int W = 2 + DEST_W + 32;

  logic              iClk;
  logic              iReset_n;
  logic              iValid;
  logic              oReady;
  logic [31:0]       iRegC;
  logic              iNEG;
  logic              iZERO;
  logic [3:0]        iOP;
  logic [DEST_W-1:0] iDest;
  logic              oValid;
  logic              iReady;
  logic [31:0]       oData;
  logic [DEST_W-1:0] oDest;
  logic              oWrEn;
  logic              oFlagN;
  logic              oFlagZ;
  logic [1:0]        oCount;
`ifdef ALU_BRANCH_COND_EN
  logic [2:0]        iCond;
  logic              oTaken;
`endif

  int n_checks = 0;
  int n_errors = 0;

  alu_result_stage #(.DEST_W(DEST_W)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iValid(iValid), .oReady(oReady),
    .iRegC(iRegC), .iNEG(iNEG), .iZERO(iZERO), .iOP(iOP), .iDest(iDest),
    .oValid(oValid), .iReady(iReady), .oData(oData), .oDest(oDest), .oWrEn(oWrEn),
    .oFlagN(oFlagN), .oFlagZ(oFlagZ),
`ifdef ALU_BRANCH_COND_EN
    .iCond(iCond), .oTaken(oTaken),
`endif
    .oCount(oCount)
  );

  // Clock / reset
  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entry = {taken, wren, dest, data}
  logic [W-1:0] exp_q[$];
  logic m_rdy;
  logic m_n;
  logic m_z;

  function automatic logic model_taken(input logic [2:0] c, input logic n, input logic z);
    case (c)
      3'd0: return 1'b0;
      3'd1: return 1'b1;
      3'd2: return z;
      3'd3: return !z;
      3'd4: return n;
      3'd5: return !n;
      3'd6: return n || z;
      default: return !n && !z;
    endcase
  endfunction

  always @(posedge iClk or negedge iReset_n) begin : model
    bit do_push;
    bit do_pop;
    logic tk;
    if (!iReset_n) begin
      exp_q.delete();
      m_rdy <= 1'b0;
      m_n   <= 1'b0;
      m_z   <= 1'b0;
    end else begin
      do_push = iValid && m_rdy && (exp_q.size() < 2);
      do_pop  = iReady && (exp_q.size() > 0);
      tk = 1'b0;
`ifdef ALU_BRANCH_COND_EN
      tk = model_taken(iCond, m_n, m_z);
`endif
      if (do_pop) void'(exp_q.pop_front());
      if (do_push) exp_q.push_back({tk, iOP != 4'd0, iDest, iRegC});
      if (do_push && (iOP == 4'd1 || iOP == 4'd2)) begin
        m_n <= iNEG;
        m_z <= iZERO;
      end
      m_rdy <= 1'b1;
    end
  end

  // Per-cycle compare against the model
  always @(negedge iClk) begin : compare
    logic [W-1:0] e;
    e = (exp_q.size() != 0) ? exp_q[0] : '0;
    check("valid", 64'(oValid), 64'(exp_q.size() != 0));
    check("data",  64'(oData),  64'(e[31:0]));
    check("dest",  64'(oDest),  64'(e[32 +: DEST_W]));
    check("wren",  64'(oWrEn),  64'(e[32+DEST_W]));
    check("count", 64'(oCount), 64'(exp_q.size()));
    check("ready", 64'(oReady), 64'(m_rdy && exp_q.size() < 2));
    check("flag_n", 64'(oFlagN), 64'(m_n));
    check("flag_z", 64'(oFlagZ), 64'(m_z));
`ifdef ALU_BRANCH_COND_EN
    check("taken", 64'(oTaken), 64'(e[W-1]));
`endif
  end

  // Driver tasks: inputs change 1 time unit after the rising edge
  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic drive(input logic [31:0] d, input logic [3:0] op, input logic [DEST_W-1:0] dst,
                       input logic n, input logic z, input logic [2:0] c);
    iValid = 1'b1;
    iRegC  = d;
    iOP    = op;
    iDest  = dst;
    iNEG   = n;
    iZERO  = z;
`ifdef ALU_BRANCH_COND_EN
    iCond  = c;
`else
    if (c != 3'd0) iRegC = d;
`endif
  endtask

  initial begin
    iReset_n = 1'b1;
    iValid = 1'b0; iRegC = '0; iOP = '0; iDest = '0; iNEG = 1'b0; iZERO = 1'b0; iReady = 1'b0;
`ifdef ALU_BRANCH_COND_EN
    iCond = '0;
`endif
    #1 iReset_n = 1'b0;
    #2;
    check("reset_valid", 64'(oValid), 64'd0);
    check("reset_ready", 64'(oReady), 64'd0);
    step(); step();
    iReset_n = 1'b1;

    // First result after reset release; oReady low for one cycle
    iReady = 1'b1;
    drive(32'h12, 4'd1, 4'd3, 1'b0, 1'b0, 3'd0);
    #2 check("ready_after_release", 64'(oReady), 64'd0);
    step();
    check("ready_second_cycle", 64'(oReady), 64'd1);
    step();
    check("first_data", 64'(oData), 64'h12);
    check("first_dest", 64'(oDest), 64'd3);
    check("first_wren", 64'(oWrEn), 64'd1);
    check("first_flags", 64'({oFlagN, oFlagZ}), 64'd0);
    iValid = 1'b0;
    step();

    // Backpressure: two absorbed, third held, then in-order drain
    iReady = 1'b0;
    drive(32'hA, 4'd3, 4'd1, 1'b0, 1'b0, 3'd0);
    step();
    drive(32'hB, 4'd3, 4'd2, 1'b0, 1'b0, 3'd0);
    step();
    drive(32'hC, 4'd3, 4'd4, 1'b0, 1'b0, 3'd0);
    check("full_count", 64'(oCount), 64'd2);
    check("full_ready", 64'(oReady), 64'd0);
    check("full_head", 64'(oData), 64'hA);
    step();
    check("held_count", 64'(oCount), 64'd2);
    iReady = 1'b1;
    step();
    check("drain_b", 64'(oData), 64'hB);
    step();
    check("drain_c", 64'(oData), 64'hC);
    iValid = 1'b0;
    step();
    check("drained", 64'(oCount), 64'd0);

    // Flag update only on opcodes 1/2
    drive(32'h20, 4'd2, 4'd5, 1'b0, 1'b1, 3'd0);
    step();
    check("flag_z_set", 64'(oFlagZ), 64'd1);
    drive(32'h21, 4'd0, 4'd6, 1'b0, 1'b0, 3'd0);
    step();
    check("flag_z_kept", 64'(oFlagZ), 64'd1);
    check("nop_wren", 64'(oWrEn), 64'd0);
    iValid = 1'b0;
    step();

    // Sustained streaming
    for (int i = 0; i < 16; i++) begin
      drive(32'h100 + 32'(i), 4'(i % 4), 4'(i), i[0], i[1], 3'd0);
      step();
      check("stream_count", 64'(oCount), 64'd1);
      check("stream_data", 64'(oData), 64'h100 + 64'(i));
    end
    iValid = 1'b0;
    step();

    // Reset while full clears everything at once
    iReady = 1'b0;
    drive(32'h55, 4'd1, 4'd7, 1'b1, 1'b0, 3'd0);
    step();
    drive(32'h66, 4'd1, 4'd8, 1'b1, 1'b0, 3'd0);
    step();
    iValid = 1'b0;
    check("pre_reset_count", 64'(oCount), 64'd2);
    check("pre_reset_flag_n", 64'(oFlagN), 64'd1);
    #2 iReset_n = 1'b0;
    #1;
    check("async_valid", 64'(oValid), 64'd0);
    check("async_data", 64'(oData), 64'd0);
    check("async_count", 64'(oCount), 64'd0);
    check("async_flags", 64'({oFlagN, oFlagZ}), 64'd0);
    check("async_ready", 64'(oReady), 64'd0);
    step();
    iReset_n = 1'b1;
    iReady = 1'b1;
    step(); step();
    check("no_stale", 64'(oValid), 64'd0);

`ifdef ALU_BRANCH_COND_EN
    // Branch conditions evaluated on pre-update flags
    drive(32'h1, 4'd1, 4'd1, 1'b1, 1'b0, 3'd0);
    step();
    check("cond0_taken", 64'(oTaken), 64'd0);
    drive(32'h2, 4'd0, 4'd2, 1'b0, 1'b0, 3'd4);
    step();
    check("cond4_taken", 64'(oTaken), 64'd1);
    drive(32'h3, 4'd0, 4'd3, 1'b0, 1'b0, 3'd7);
    step();
    check("cond7_taken", 64'(oTaken), 64'd0);
    drive(32'h4, 4'd0, 4'd4, 1'b0, 1'b0, 3'd1);
    step();
    check("cond1_taken", 64'(oTaken), 64'd1);
    iValid = 1'b0;
    step();
`endif

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
